// File: rtl/la_cmd_pkg.sv
// ============================================================================
// Module  : la_cmd_pkg
// Brief   : Opcodes, error codes, FSM encoding and defaults for uart_cmd_ctrl
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package la_cmd_pkg;

  localparam logic [7:0] OP_DEFAULTS = 8'h00;
  localparam logic [7:0] OP_ARM      = 8'h01;
  localparam logic [7:0] OP_ABORT    = 8'h02;
  localparam logic [7:0] OP_DIV      = 8'h10;
  localparam logic [7:0] OP_MASK     = 8'h11;
  localparam logic [7:0] OP_VALUE    = 8'h12;
  localparam logic [7:0] OP_EDGE     = 8'h13;
  localparam logic [7:0] OP_COUNT    = 8'h14;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_UNKNOWN_OP = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT    = 2'd2;
  localparam logic [1:0] ERR_BUSY       = 2'd3;

  localparam logic [31:0] LA_DEFAULT_DIV   = 32'd50;
  localparam logic [15:0] LA_DEFAULT_COUNT = 16'd1024;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARGS   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  function automatic logic op_known(input logic [7:0] op);
    case (op)
      OP_DEFAULTS, OP_ARM, OP_ABORT,
      OP_DIV, OP_MASK, OP_VALUE, OP_EDGE, OP_COUNT: op_known = 1'b1;
      default:                                      op_known = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] arg_len(input logic [7:0] op);
    case (op)
      OP_DIV:                      arg_len = 3'd4;
      OP_COUNT:                    arg_len = 3'd2;
      OP_MASK, OP_VALUE, OP_EDGE:  arg_len = 3'd1;
      default:                     arg_len = 3'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/async_level_strobe.sv
// ============================================================================
// Module  : async_level_strobe
// Brief   : 2-flop synchronizer plus rising-edge detector -> one-cycle strobe
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module async_level_strobe (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic level_i,
  output logic strobe_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= level_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign strobe_o = sync2_q & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
// ============================================================================
// Module  : uart_cmd_ctrl
// Brief   : Frames UART bytes into commands and commits capture configuration
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_ctrl
  import la_cmd_pkg::*;
#(
  parameter int          CHANNELS       = 8,
  parameter int          TIMEOUT_CYCLES = 2500000,
  parameter logic [31:0] DEFAULT_DIV    = LA_DEFAULT_DIV,
  parameter logic [15:0] DEFAULT_COUNT  = LA_DEFAULT_COUNT
) (
  input  logic                i_clk,
  input  logic                _rst,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_avail,
  input  logic                i_capturing,
  output logic [31:0]         o_sample_div,
  output logic [15:0]         o_sample_count,
  output logic [CHANNELS-1:0] o_trig_mask,
  output logic [CHANNELS-1:0] o_trig_value,
  output logic [CHANNELS-1:0] o_trig_edge,
  output logic                o_cfg_update,
  output logic                o_arm,
  output logic                o_abort,
  output logic                o_err,
  output logic [1:0]          o_err_code
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic w_strobe;

  async_level_strobe u_strobe (
    .clk_i    (i_clk),
    .rst_ni   (_rst),
    .level_i  (i_rx_avail),
    .strobe_o (w_strobe)
  );

  state_e              state_q,     state_d;
  logic [7:0]          op_q,        op_d;
  logic [2:0]          left_q,      left_d;
  logic [31:0]         shadow_q,    shadow_d;
  logic [TW-1:0]       tmo_q,       tmo_d;
  logic                pend_q,      pend_d;
  logic [7:0]          pend_data_q, pend_data_d;
  logic [31:0]         div_q,       div_d;
  logic [15:0]         count_q,     count_d;
  logic [CHANNELS-1:0] mask_q,      mask_d;
  logic [CHANNELS-1:0] value_q,     value_d;
  logic [CHANNELS-1:0] tedge_q,     tedge_d;
  logic                cfg_q,       cfg_d;
  logic                arm_q,       arm_d;
  logic                abort_q,     abort_d;
  logic                err_q,       err_d;
  logic [1:0]          code_q,      code_d;

  logic       w_vld;
  logic [7:0] w_byte;
  logic [7:0] w_arg8;

  // A byte parked during COMMIT takes priority over a fresh strobe.
  assign w_vld  = pend_q | w_strobe;
  assign w_byte = pend_q ? pend_data_q : i_rx_data;
  assign w_arg8 = shadow_q[31:24];

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    left_d      = left_q;
    shadow_d    = shadow_q;
    tmo_d       = tmo_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    div_d       = div_q;
    count_d     = count_q;
    mask_d      = mask_q;
    value_d     = value_q;
    tedge_d     = tedge_q;
    cfg_d       = 1'b0;
    arm_d       = 1'b0;
    abort_d     = 1'b0;
    err_d       = 1'b0;
    code_d      = code_q;

    if (state_q == ST_COMMIT) begin
      if (w_strobe) begin
        pend_d      = 1'b1;
        pend_data_d = i_rx_data;
      end
    end else if (pend_q) begin
      pend_d = w_strobe;
      if (w_strobe) pend_data_d = i_rx_data;
    end

    if (state_q != ST_ARGS || w_vld) tmo_d = '0;
    else                             tmo_d = tmo_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (w_vld) begin
          if (op_known(w_byte)) begin
            op_d     = w_byte;
            left_d   = arg_len(w_byte);
            shadow_d = '0;
            state_d  = (arg_len(w_byte) == 3'd0) ? ST_COMMIT : ST_ARGS;
          end else begin
            err_d  = 1'b1;
            code_d = ERR_UNKNOWN_OP;
          end
        end
      end

      ST_ARGS: begin
        if (w_vld) begin
          // Little-endian: shifting right leaves the final arguments MSB-aligned.
          shadow_d = {w_byte, shadow_q[31:8]};
          left_d   = left_q - 3'd1;
          if (left_q == 3'd1) state_d = ST_COMMIT;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d    = 1'b1;
          code_d   = ERR_TIMEOUT;
          shadow_d = '0;
          state_d  = ST_IDLE;
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (op_q == OP_ABORT) begin
          abort_d = 1'b1;
        end else if (i_capturing) begin
          err_d  = 1'b1;
          code_d = ERR_BUSY;
        end else begin
          case (op_q)
            OP_DEFAULTS: begin
              div_d   = DEFAULT_DIV;
              count_d = DEFAULT_COUNT;
              mask_d  = '0;
              value_d = '0;
              tedge_d = '0;
              cfg_d   = 1'b1;
            end
            OP_ARM:   arm_d = 1'b1;
            OP_DIV: begin
              div_d = shadow_q;
              cfg_d = 1'b1;
            end
            OP_COUNT: begin
              count_d = shadow_q[31:16];
              cfg_d   = 1'b1;
            end
            OP_MASK: begin
              mask_d = w_arg8[CHANNELS-1:0];
              cfg_d  = 1'b1;
            end
            OP_VALUE: begin
              value_d = w_arg8[CHANNELS-1:0];
              cfg_d   = 1'b1;
            end
            OP_EDGE: begin
              tedge_d = w_arg8[CHANNELS-1:0];
              cfg_d   = 1'b1;
            end
            default: ;
          endcase
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      state_q     <= ST_IDLE;
      op_q        <= '0;
      left_q      <= '0;
      shadow_q    <= '0;
      tmo_q       <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      div_q       <= DEFAULT_DIV;
      count_q     <= DEFAULT_COUNT;
      mask_q      <= '0;
      value_q     <= '0;
      tedge_q     <= '0;
      cfg_q       <= 1'b0;
      arm_q       <= 1'b0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      code_q      <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      left_q      <= left_d;
      shadow_q    <= shadow_d;
      tmo_q       <= tmo_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      div_q       <= div_d;
      count_q     <= count_d;
      mask_q      <= mask_d;
      value_q     <= value_d;
      tedge_q     <= tedge_d;
      cfg_q       <= cfg_d;
      arm_q       <= arm_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
      code_q      <= code_d;
    end
  end

  assign o_sample_div   = div_q;
  assign o_sample_count = count_q;
  assign o_trig_mask    = mask_q;
  assign o_trig_value   = value_q;
  assign o_trig_edge    = tedge_q;
  assign o_cfg_update   = cfg_q;
  assign o_arm          = arm_q;
  assign o_abort        = abort_q;
  assign o_err          = err_q;
  assign o_err_code     = code_q;

endmodule

`default_nettype wire

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command sequencer between the UART receiver and the logic-analyzer capture engine.
- Consumes received bytes (data plus "avail" level), frames them into opcode+argument commands and commits sampling/trigger configuration atomically.
- Issues one-cycle arm/abort pulses to the capture engine and reports framing errors to the status path.

Parameters:
- CHANNELS, 8, probe channel count; legal range 1..8, so trigger arguments fit in one byte.
- TIMEOUT_CYCLES, 2500000, maximum i_clk cycles between argument bytes (50 ms at 50 MHz).
- DEFAULT_DIV, 50, reset value of o_sample_div.
- DEFAULT_COUNT, 1024, reset value of o_sample_count.

Ports:
- i_clk  in  1  system clock.
- _rst  in  1  reset, asynchronous, active-low.
- i_rx_data  in  8  received byte; stable while i_rx_avail is high.
- i_rx_avail  in  1  byte-available level from the UART receiver; asynchronous to i_clk.
- i_capturing  in  1  capture engine running.
- o_sample_div  out  32  sample clock divider.
- o_sample_count  out  16  samples per capture.
- o_trig_mask  out  CHANNELS  channels participating in the trigger.
- o_trig_value  out  CHANNELS  trigger level or edge polarity.
- o_trig_edge  out  CHANNELS  1 = edge trigger, 0 = level trigger, per channel.
- o_cfg_update  out  1  one-cycle pulse when configuration has changed.
- o_arm  out  1  one-cycle start-capture pulse.
- o_abort  out  1  one-cycle stop-capture pulse.
- o_err  out  1  one-cycle error pulse.
- o_err_code  out  2  error code; holds its value until the next error.

Behaviour:
- Reset state: o_sample_div=DEFAULT_DIV, o_sample_count=DEFAULT_COUNT, all trigger outputs 0, all pulse outputs 0, o_err_code=0, FSM in IDLE.
- Byte strobe:
  - i_rx_avail passes through a 2-flop synchronizer, then a rising-edge detector.
  - The strobe is high in the first cycle in which the synchronized value is 1 after being 0.
  - i_rx_data is captured in the strobe cycle.
- Opcodes and argument byte counts:
  - 0x00 DEFAULTS (0), 0x01 ARM (0), 0x02 ABORT (0).
  - 0x10 DIV (4, little-endian), 0x11 MASK (1), 0x12 VALUE (1), 0x13 EDGE (1), 0x14 COUNT (2, little-endian).
  - Byte arguments are truncated to their low CHANNELS bits.
- FSM states: IDLE, ARGS, COMMIT.
  - IDLE + strobe with a known opcode: latch the opcode and argument count. Zero arguments -> COMMIT; otherwise -> ARGS.
  - IDLE + strobe with an unknown opcode: error UNKNOWN_OP (code 1); stay in IDLE.
  - ARGS: each strobe shifts the byte into a 32-bit shadow register and decrements the count. The last byte -> COMMIT.
  - COMMIT lasts exactly one cycle; always -> IDLE.
- Commit timing:
  - The final byte's strobe occurs at edge k.
  - Target register update and the o_cfg_update / o_arm / o_abort pulse occur at edge k+1 and deassert at edge k+2.
  - Outputs never show partially received arguments.
- Busy rule:
  - While i_capturing=1, DEFAULTS, ARM and all SET commands are rejected at COMMIT.
  - Rejection means no register change and error BUSY (code 3).
  - Argument bytes of a rejected command are still consumed.
  - ABORT is always accepted.
- Timeout:
  - The timeout counter resets on every strobe and runs only in ARGS.
  - Reaching TIMEOUT_CYCLES -> error TIMEOUT (code 2), shadow register discarded, -> IDLE.
  - A strobe in the same cycle the counter expires wins: the byte is accepted and there is no error.
- Error pulse: o_err is high for one cycle; o_err_code updates in the same cycle and is otherwise held.
- Reset mid-command: everything returns to reset values immediately; partial arguments are lost.
- Strobe during COMMIT: impossible in practice because of the synchronizer latency. If it does occur, it is handled in the following IDLE cycle via a one-entry pending flag; no bytes are dropped.

Decomposition:
- Package la_cmd_pkg holds:
  - opcode constants;
  - error codes (NONE=0, UNKNOWN_OP=1, TIMEOUT=2, BUSY=3);
  - an argument-length function of the opcode;
  - FSM state encoding;
  - DEFAULT_DIV and DEFAULT_COUNT values.
- One sub-module, async_level_strobe: the 2-flop synchronizer plus rising-edge detector, producing a single-cycle strobe.

Test Plan:
- Bytes 0x10,0x40,0x42,0x0F,0x00 -> o_sample_div=0x000F4240 one cycle after the last strobe; o_cfg_update high for 1 cycle; o_sample_div unchanged before that.
- Byte 0x01 with i_capturing=0 -> o_arm high for exactly 1 cycle; no o_cfg_update.
- i_capturing=1, bytes 0x14,0x00,0x08 -> o_sample_count stays 1024; o_err pulses with o_err_code=3. A following 0x02 still yields an o_abort pulse.
- Bytes 0x10,0xAA then silence for TIMEOUT_CYCLES -> o_err with o_err_code=2. Next bytes 0x11,0x0F -> o_trig_mask=0x0F.
- Byte 0x7E -> o_err with o_err_code=1; FSM back in IDLE. Next bytes 0x12,0x81 -> o_trig_value=0x81.
- _rst asserted after 0x10,0x01 -> all outputs return to defaults asynchronously. After release, a lone 0x01 -> o_arm pulse, showing no leftover argument state.
